// File: rtl/ssd_scan_scheduler.sv
// ssd_scan_scheduler
//   Drives the Nexys4 8-digit seven-segment display for the game. Digits 3..0
//   show value_a (sun count), digits 7..4 show value_b (zombies killed). Once
//   per frame both counters are snapshotted and converted to BCD by a shared
//   sequential double-dabble engine. The anodes are time-multiplexed with a
//   fixed dwell of DIGIT_CYCLES clocks per digit.
//
// Ports
//   clk          system clock (100 MHz)
//   reset_n      asynchronous active-low reset
//   value_a      unsigned counter shown on digits 3..0
//   value_b      unsigned counter shown on digits 7..4
//   anode        active-low digit enables, bit i = An i
//   seg          active-low segments {Ca,Cb,Cc,Cd,Ce,Cf,Cg}
//   dp           active-low decimal point (always off)
//   frame_start  one-cycle pulse on the first cycle of digit 0
//   sat_a/sat_b  high while the displayed value is clamped to 9999
module ssd_scan_scheduler #(
    parameter int DIGIT_CYCLES  = 100000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value_a,
    input  logic [15:0] value_b,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start,
    output logic        sat_a,
    output logic        sat_b
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, SHIFT_A, COMMIT_A, LOAD_B, SHIFT_B, COMMIT_B
    } state_t;

    state_t state, stateNext;

    logic [CNT_W-1:0] dwellCnt;
    logic [2:0]       digitIdx;
    logic [2:0]       idxNext;
    logic             dwellWrap;
    logic [6:0]       segNext;

    logic [15:0] binReg;
    logic [19:0] bcdReg;
    logic [19:0] bcdAdj;
    logic [19:0] bcdNext;
    logic [3:0]  shiftCnt;
    logic [15:0] digA;
    logic [15:0] digB;
    logic        firstPass;

    function automatic logic [6:0] segDecode(input logic [3:0] nib);
        case (nib)
            4'd0:    segDecode = 7'b0000001;
            4'd1:    segDecode = 7'b1001111;
            4'd2:    segDecode = 7'b0010010;
            4'd3:    segDecode = 7'b0000110;
            4'd4:    segDecode = 7'b1001100;
            4'd5:    segDecode = 7'b0100100;
            4'd6:    segDecode = 7'b0100000;
            4'd7:    segDecode = 7'b0001111;
            4'd8:    segDecode = 7'b0000000;
            4'd9:    segDecode = 7'b0000100;
            default: segDecode = 7'b1111111;
        endcase
    endfunction

    assign dp = 1'b1;

    // ---------------- scan counter and registered display outputs ----------
    always_comb begin
        dwellWrap = (dwellCnt == CNT_W'(DIGIT_CYCLES - 1));
        idxNext   = dwellWrap ? digitIdx + 3'd1 : digitIdx;
    end

    // Segment pattern is computed for the digit that will be lit after the
    // next edge, so anode and seg are loaded together on the same edge.
    always_comb begin
        logic [15:0] grp;
        logic [15:0] upper;
        logic [1:0]  pos;
        logic [3:0]  nib;
        logic        blank;
        grp     = idxNext[2] ? digB : digA;
        pos     = idxNext[1:0];
        nib     = grp[{pos, 2'b00} +: 4];
        upper   = grp >> {pos, 2'b00};
        blank   = (BLANK_LEADING != 0) && (pos != 2'd0) && (upper == 16'd0);
        segNext = blank ? 7'h7F : segDecode(nib);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwellCnt    <= '0;
            digitIdx    <= '0;
            frame_start <= 1'b0;
            anode       <= '1;
            seg         <= '1;
        end else begin
            dwellCnt    <= dwellWrap ? '0 : dwellCnt + CNT_W'(1);
            digitIdx    <= idxNext;
            frame_start <= dwellWrap && (digitIdx == 3'd7);
            anode       <= ~(8'd1 << idxNext);
            seg         <= segNext;
        end
    end

    // ---------------- conversion FSM ----------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    // frame_start arriving outside IDLE is simply not looked at.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (frame_start || firstPass) stateNext = LOAD_A;
            LOAD_A:   stateNext = SHIFT_A;
            SHIFT_A:  if (shiftCnt == 4'd15) stateNext = COMMIT_A;
            COMMIT_A: stateNext = LOAD_B;
            LOAD_B:   stateNext = SHIFT_B;
            SHIFT_B:  if (shiftCnt == 4'd15) stateNext = COMMIT_B;
            COMMIT_B: stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin}.
    always_comb begin
        bcdAdj = bcdReg;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcdReg[i*4 +: 4] >= 4'd5) bcdAdj[i*4 +: 4] = bcdReg[i*4 +: 4] + 4'd3;
        end
        bcdNext = (bcdAdj << 1) | {19'd0, binReg[15]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            binReg    <= '0;
            bcdReg    <= '0;
            shiftCnt  <= '0;
            digA      <= '0;
            digB      <= '0;
            sat_a     <= 1'b0;
            sat_b     <= 1'b0;
            firstPass <= 1'b1;
        end else begin
            case (state)
                IDLE: firstPass <= 1'b0;
                LOAD_A, LOAD_B: begin
                    binReg   <= (state == LOAD_A) ? value_a : value_b;
                    bcdReg   <= '0;
                    shiftCnt <= '0;
                end
                SHIFT_A, SHIFT_B: begin
                    bcdReg   <= bcdNext;
                    binReg   <= {binReg[14:0], 1'b0};
                    shiftCnt <= shiftCnt + 4'd1;
                end
                COMMIT_A: begin
                    sat_a <= (bcdReg[19:16] != 4'd0);
                    digA  <= (bcdReg[19:16] != 4'd0) ? 16'h9999 : bcdReg[15:0];
                end
                COMMIT_B: begin
                    sat_b <= (bcdReg[19:16] != 4'd0);
                    digB  <= (bcdReg[19:16] != 4'd0) ? 16'h9999 : bcdReg[15:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ssd_scan_scheduler.sv
module tb_ssd_scan_scheduler;

    localparam int DC = 32;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S7 = 7'b0001111;
    localparam logic [6:0] S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111;

    logic        clk;
    logic        reset_n;
    logic [15:0] value_a;
    logic [15:0] value_b;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_start;
    logic        sat_a;
    logic        sat_b;

    int checks = 0;
    int errors = 0;

    ssd_scan_scheduler #(.DIGIT_CYCLES(DC), .BLANK_LEADING(1)) dut (
        .clk(clk), .reset_n(reset_n), .value_a(value_a), .value_b(value_b),
        .anode(anode), .seg(seg), .dp(dp), .frame_start(frame_start),
        .sat_a(sat_a), .sat_b(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait (bounded) until digit d is lit.
    task automatic waitAnode(input int d, output bit ok);
        logic [7:0] target;
        target = ~(8'd1 << d);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (anode === target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Wait (bounded) for a frame_start pulse, returning on that cycle.
    task automatic waitFrame(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Capture the segment pattern of each digit 0..7 in scan order.
    task automatic scanFrame(output logic [55:0] segs, output bit ok);
        bit w;
        ok   = 1'b1;
        segs = '1;
        for (int d = 0; d < 8; d++) begin
            waitAnode(d, w);
            if (!w) ok = 1'b0;
            repeat (2) @(negedge clk);
            segs[d*7 +: 7] = seg;
        end
    endtask

    task automatic test_reset;
        logic [55:0] segs;
        logic [6:0]  expd [8];
        bit ok;
        value_a = 16'd1234;
        value_b = 16'd0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (anode !== 8'hFF) begin errors++; $display("FAIL reset_anode got %h want ff", anode); end
        checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %b want 1111111", seg); end
        checks++; if (dp !== 1'b1) begin errors++; $display("FAIL reset_dp got %b want 1", dp); end
        checks++; if ({frame_start, sat_a, sat_b} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {frame_start, sat_a, sat_b});
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (anode !== 8'hFE) begin errors++; $display("FAIL first_anode got %h want fe", anode); end
        repeat (36) @(negedge clk);
        waitAnode(3, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok || anode !== 8'hF7 || seg !== S1) begin
            errors++; $display("FAIL reset_digit3 got anode=%h seg=%b want anode=f7 seg=%b", anode, seg, S1);
        end
        expd = '{S4, S3, S2, S1, S0, SB, SB, SB};
        scanFrame(segs, ok);
        checks++; if (!ok) begin errors++; $display("FAIL reset_scan_timeout got 0 want 1"); end
        for (int d = 0; d < 8; d++) begin
            checks++; if (segs[d*7 +: 7] !== expd[d]) begin
                errors++; $display("FAIL reset_digit%0d got %b want %b", d, segs[d*7 +: 7], expd[d]);
            end
        end
    endtask

    task automatic test_blanking;
        logic [55:0] segs;
        logic [6:0]  expd [8];
        bit ok;
        value_a = 16'd7;
        value_b = 16'd0;
        waitFrame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL blank_frame_timeout got 0 want 1"); end
        repeat (40) @(negedge clk);
        checks++; if ({sat_a, sat_b} !== 2'b00) begin errors++; $display("FAIL blank_sat got %b want 00", {sat_a, sat_b}); end
        expd = '{S7, SB, SB, SB, S0, SB, SB, SB};
        scanFrame(segs, ok);
        for (int d = 0; d < 8; d++) begin
            checks++; if (!ok || segs[d*7 +: 7] !== expd[d]) begin
                errors++; $display("FAIL blank_digit%0d got %b want %b", d, segs[d*7 +: 7], expd[d]);
            end
        end
    endtask

    task automatic test_saturation;
        logic [55:0] segs;
        logic [6:0]  expd [8];
        bit ok;
        expd = '{S7, SB, SB, SB, S9, S9, S9, S9};
        value_b = 16'hFFFF;
        waitFrame(ok);
        repeat (40) @(negedge clk);
        checks++; if (!ok || sat_b !== 1'b1 || sat_a !== 1'b0) begin
            errors++; $display("FAIL sat_high got sat_a=%b sat_b=%b want 0 1", sat_a, sat_b);
        end
        scanFrame(segs, ok);
        for (int d = 4; d < 8; d++) begin
            checks++; if (!ok || segs[d*7 +: 7] !== expd[d]) begin
                errors++; $display("FAIL sat_digit%0d got %b want %b", d, segs[d*7 +: 7], expd[d]);
            end
        end
        value_b = 16'd9999;
        waitFrame(ok);
        repeat (40) @(negedge clk);
        checks++; if (!ok || sat_b !== 1'b0) begin errors++; $display("FAIL sat_clear got %b want 0", sat_b); end
        scanFrame(segs, ok);
        for (int d = 0; d < 8; d++) begin
            checks++; if (!ok || segs[d*7 +: 7] !== expd[d]) begin
                errors++; $display("FAIL sat9999_digit%0d got %b want %b", d, segs[d*7 +: 7], expd[d]);
            end
        end
    endtask

    task automatic test_scan_timing;
        logic [7:0] expA;
        int badOrder;
        int multiLow;
        int fsCount;
        bit ok;
        badOrder = 0;
        multiLow = 0;
        fsCount  = 0;
        waitFrame(ok);
        checks++; if (!ok) begin errors++; $display("FAIL scan_frame_timeout got 0 want 1"); end
        for (int i = 0; i < 256; i++) begin
            expA = ~(8'd1 << (i / DC));
            if (anode !== expA) badOrder++;
            if ($countones(~anode) != 1) multiLow++;
            if (frame_start === 1'b1) fsCount++;
            @(negedge clk);
        end
        checks++; if (badOrder != 0) begin errors++; $display("FAIL scan_order got %0d bad cycles want 0", badOrder); end
        checks++; if (multiLow != 0) begin errors++; $display("FAIL scan_onehot got %0d bad cycles want 0", multiLow); end
        checks++; if (fsCount != 1) begin errors++; $display("FAIL scan_fs_count got %0d want 1", fsCount); end
        checks++; if (frame_start !== 1'b1 || anode !== 8'hFE) begin
            errors++; $display("FAIL scan_period got fs=%b anode=%h want 1 fe", frame_start, anode);
        end
    endtask

    task automatic test_midconv;
        logic [55:0] segs;
        bit ok, ok2;
        value_a = 16'd1000;
        waitFrame(ok);
        waitFrame(ok2);
        waitFrame(ok);
        ok = ok && ok2;
        repeat (4) @(negedge clk);
        value_a = 16'd2000;
        scanFrame(segs, ok2);
        checks++; if (!ok || !ok2 || segs[27:0] !== {S1, S0, S0, S0}) begin
            errors++; $display("FAIL midconv_old got %h want %h", segs[27:0], {S1, S0, S0, S0});
        end
        scanFrame(segs, ok);
        checks++; if (!ok || segs[27:0] !== {S2, S0, S0, S0}) begin
            errors++; $display("FAIL midconv_new got %h want %h", segs[27:0], {S2, S0, S0, S0});
        end
    endtask

    task automatic test_async_reset;
        logic [55:0] segs;
        logic [6:0]  expd [8];
        bit ok;
        value_a = 16'd5678;
        value_b = 16'hFFFF;
        waitFrame(ok);
        waitFrame(ok);
        repeat (25) @(negedge clk);
        checks++; if (!ok || sat_b !== 1'b1) begin errors++; $display("FAIL areset_pre_sat got %b want 1", sat_b); end
        reset_n = 1'b0;
        #1;
        checks++; if ({anode, seg, frame_start, sat_a, sat_b} !== {8'hFF, 7'h7F, 3'b000}) begin
            errors++; $display("FAIL areset_outputs got anode=%h seg=%b flags=%b want ff 1111111 000",
                               anode, seg, {frame_start, sat_a, sat_b});
        end
        repeat (3) @(negedge clk);
        value_a = 16'd42;
        value_b = 16'd300;
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if ({sat_a, sat_b} !== 2'b00) begin errors++; $display("FAIL areset_post_sat got %b want 00", {sat_a, sat_b}); end
        expd = '{S2, S4, SB, SB, S0, S0, S3, SB};
        scanFrame(segs, ok);
        for (int d = 0; d < 8; d++) begin
            checks++; if (!ok || segs[d*7 +: 7] !== expd[d]) begin
                errors++; $display("FAIL areset_digit%0d got %b want %b", d, segs[d*7 +: 7], expd[d]);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        value_a = '0;
        value_b = '0;
        @(negedge clk);
        test_reset();
        test_blanking();
        test_saturation();
        test_scan_timing();
        test_midconv();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
